// File: rtl/gate_pipe_unit.sv
// Two-stage valid/ready pipeline that applies one of eight bitwise ops to a pair of
// operands. It also reports the popcount of the result, an operand-equality flag, and a
// saturating count of delivered items whose operands were equal.
module gate_pipe_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  localparam int ONES_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  y,
  output logic [ONES_W-1:0] ones,
  output logic              eq,
  input  logic              clr_count,
  output logic [CNT_W-1:0]  eq_count
);

  logic              s1_v;
  logic [WIDTH-1:0]  y1;
  logic              eq1;
  logic [WIDTH-1:0]  y1_next;
  logic [ONES_W-1:0] ones_next;
  logic              s1_load;
  logic              s2_load;

  // S2 may take the S1 item when S2 is empty or its item leaves this cycle;
  // S1 is ready when empty or when its item moves on, so an accept never overwrites.
  assign s2_load  = s1_v && (!out_valid || out_ready);
  assign in_ready = !s1_v || s2_load;
  assign s1_load  = in_valid && in_ready;

  // Operation select; NOT and BUF ignore b.
  always_comb begin
    y1_next = '0;
    case (op)
      3'b000:  y1_next = a & b;
      3'b001:  y1_next = a | b;
      3'b010:  y1_next = a ^ b;
      3'b011:  y1_next = ~(a ^ b);
      3'b100:  y1_next = ~(a & b);
      3'b101:  y1_next = ~(a | b);
      3'b110:  y1_next = ~a;
      default: y1_next = a;
    endcase
  end

  // Popcount of the S1 result, computed on the way into S2.
  always_comb begin
    ones_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_next = ones_next + ONES_W'(y1[i]);
    end
  end

  // Stage 1 register: captures the op result and the equality flag on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      y1   <= '0;
      eq1  <= 1'b0;
    end else if (s1_load) begin
      s1_v <= 1'b1;
      y1   <= y1_next;
      eq1  <= &(~(a ^ b));
    end else if (s2_load) begin
      s1_v <= 1'b0;
    end
  end

  // Stage 2 register: a new item replaces a departing one without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      ones      <= '0;
      eq        <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      y         <= y1;
      ones      <= ones_next;
      eq        <= eq1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of delivered equal-operand items; clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eq_count <= '0;
    end else if (clr_count) begin
      eq_count <= '0;
    end else if (out_valid && out_ready && eq && (eq_count != {CNT_W{1'b1}})) begin
      eq_count <= eq_count + CNT_W'(1);
    end
  end

endmodule
